// File: rtl/reg_file_mp_if.sv
// Bus bundle for reg_file_mp: read ports, two write ports, PC value and scoreboard signals.
interface reg_file_mp_if #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NUM_REGS = 16,
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned NUM_RD   = 3
);
    logic [NUM_RD*ADDR_W-1:0] ra;
    logic [NUM_RD*DATA_W-1:0] rd;
    logic [NUM_RD-1:0]        rd_busy;
    logic [ADDR_W-1:0]        wa0;
    logic [DATA_W-1:0]        wd0;
    logic                     we0;
    logic [ADDR_W-1:0]        wa1;
    logic [DATA_W-1:0]        wd1;
    logic                     we1;
    logic [DATA_W-1:0]        rpc;
    logic                     bset;
    logic [ADDR_W-1:0]        bset_addr;
    logic [NUM_REGS-1:0]      busy_vec;
    logic                     wr_conflict;

    modport master (
        output ra, wa0, wd0, we0, wa1, wd1, we1, rpc, bset, bset_addr,
        input  rd, rd_busy, busy_vec, wr_conflict
    );

    modport slave (
        input  ra, wa0, wd0, we0, wa1, wd1, we1, rpc, bset, bset_addr,
        output rd, rd_busy, busy_vec, wr_conflict
    );
endinterface

// File: rtl/reg_file_mp.sv
// Multi-port register file: N combinational read ports, two write ports with optional
// write-to-read bypass, PC mapped to rpc, and a per-register pending-write scoreboard.
module reg_file_mp #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NUM_REGS = 16,
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned NUM_RD   = 3,
    parameter int unsigned PC_ADDR  = 15,
    parameter int unsigned BYPASS   = 1
) (
    input  logic          clk,
    input  logic          reset,
    reg_file_mp_if.slave  bus
);
    localparam int unsigned ADDR_SPAN = 1 << ADDR_W;

    if (ADDR_SPAN < NUM_REGS || PC_ADDR >= NUM_REGS) begin : g_param_check
        $fatal(1, "reg_file_mp: NUM_REGS must fit in ADDR_W and PC_ADDR must be < NUM_REGS");
    end

    logic [DATA_W-1:0]        regs_q [NUM_REGS];
    logic [DATA_W-1:0]        regs_d [NUM_REGS];
    logic [NUM_REGS-1:0]      busy_q, busy_d;
    logic                     wr_conflict_q, wr_conflict_d;
    logic                     hit0, hit1;
    logic [NUM_RD*DATA_W-1:0] rd_c;
    logic [NUM_RD-1:0]        rd_busy_c;

    // Next state: port 0 wins collisions; the PC slot never holds state; set beats clear.
    always_comb begin
        regs_d        = regs_q;
        busy_d        = '0;
        wr_conflict_d = 1'b0;
        hit0          = 1'b0;
        hit1          = 1'b0;
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            hit0 = bus.we0 && (bus.wa0 == ADDR_W'(r));
            hit1 = bus.we1 && (bus.wa1 == ADDR_W'(r));
            if (r == PC_ADDR) begin
                regs_d[r] = '0;
            end else begin
                if (hit0) begin
                    regs_d[r] = bus.wd0;
                end else if (hit1) begin
                    regs_d[r] = bus.wd1;
                end
                busy_d[r] = (bus.bset && (bus.bset_addr == ADDR_W'(r)))
                          || (busy_q[r] && !(hit0 || hit1));
                if (hit0 && hit1) begin
                    wr_conflict_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                regs_q[r] <= '0;
            end
            busy_q        <= '0;
            wr_conflict_q <= 1'b0;
        end else begin
            regs_q        <= regs_d;
            busy_q        <= busy_d;
            wr_conflict_q <= wr_conflict_d;
        end
    end

    // Read mux: addresses outside the register range match no entry and read as zero.
    always_comb begin
        rd_c      = '0;
        rd_busy_c = '0;
        for (int unsigned k = 0; k < NUM_RD; k++) begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                if (bus.ra[k*ADDR_W +: ADDR_W] == ADDR_W'(r)) begin
                    if (r == PC_ADDR) begin
                        rd_c[k*DATA_W +: DATA_W] = bus.rpc;
                    end else begin
                        rd_c[k*DATA_W +: DATA_W] = regs_q[r];
                        rd_busy_c[k]             = busy_q[r];
                        if (BYPASS != 0) begin
                            if (bus.we1 && (bus.wa1 == ADDR_W'(r))) begin
                                rd_c[k*DATA_W +: DATA_W] = bus.wd1;
                            end
                            if (bus.we0 && (bus.wa0 == ADDR_W'(r))) begin
                                rd_c[k*DATA_W +: DATA_W] = bus.wd0;
                            end
                        end
                    end
                end
            end
        end
    end

    assign bus.rd          = rd_c;
    assign bus.rd_busy     = rd_busy_c;
    assign bus.busy_vec    = busy_q;
    assign bus.wr_conflict = wr_conflict_q;
endmodule

// File: tb/tb_reg_file_mp.sv
// Directed scoreboard bench for reg_file_mp; runs a bypassing and a non-bypassing instance side by side.
module tb_reg_file_mp;
    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] ra;
    logic [3:0]  wa0, wa1, bset_addr;
    logic [31:0] wd0, wd1, rpc;
    logic        we0, we1, bset;

    int unsigned vecs  = 0;
    int unsigned fails = 0;
    string       tag_q[$];
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    reg_file_mp_if #(.DATA_W(32), .NUM_REGS(16), .ADDR_W(4), .NUM_RD(3)) b1 ();
    reg_file_mp_if #(.DATA_W(32), .NUM_REGS(16), .ADDR_W(4), .NUM_RD(3)) b0 ();

    assign b1.ra = ra;   assign b0.ra = ra;
    assign b1.wa0 = wa0; assign b0.wa0 = wa0;
    assign b1.wd0 = wd0; assign b0.wd0 = wd0;
    assign b1.we0 = we0; assign b0.we0 = we0;
    assign b1.wa1 = wa1; assign b0.wa1 = wa1;
    assign b1.wd1 = wd1; assign b0.wd1 = wd1;
    assign b1.we1 = we1; assign b0.we1 = we1;
    assign b1.rpc = rpc; assign b0.rpc = rpc;
    assign b1.bset = bset;           assign b0.bset = bset;
    assign b1.bset_addr = bset_addr; assign b0.bset_addr = bset_addr;

    reg_file_mp #(.DATA_W(32), .NUM_REGS(16), .ADDR_W(4), .NUM_RD(3), .PC_ADDR(15), .BYPASS(1))
        u_byp (.clk(clk), .reset(reset), .bus(b1));
    reg_file_mp #(.DATA_W(32), .NUM_REGS(16), .ADDR_W(4), .NUM_RD(3), .PC_ADDR(15), .BYPASS(0))
        u_nobyp (.clk(clk), .reset(reset), .bus(b0));

    task automatic expect_val(input string tag, input logic [31:0] exp);
        tag_q.push_back(tag);
        exp_q.push_back(exp);
    endtask

    task automatic check(input logic [31:0] obs);
        string       t;
        logic [31:0] e;
        vecs++;
        if (exp_q.size() == 0) begin
            fails++;
            $error("FAIL scoreboard_underflow: observed %h with no expectation queued", obs);
        end else begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            assert (obs === e) else begin
                fails++;
                $error("FAIL %s: observed %h expected %h", t, obs, e);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we0 = 1'b0; we1 = 1'b0; bset = 1'b0;
        #1;
    endtask

    initial begin
        reset = 1'b0; ra = {4'd0, 4'd0, 4'd3}; rpc = 32'h0000_0100;
        we0 = 1'b1; wa0 = 4'd3; wd0 = 32'hDEAD_BEEF;
        we1 = 1'b0; wa1 = 4'd0; wd1 = 32'h0;
        bset = 1'b1; bset_addr = 4'd3;
        tick(); tick();
        reset = 1'b1; idle();
        expect_val("reset_r3", 32'h0);           check(b1.rd[31:0]);
        expect_val("reset_busy_vec", 32'h0);     check(32'(b1.busy_vec));
        expect_val("reset_wr_conflict", 32'h0);  check(32'(b1.wr_conflict));
        expect_val("reset_r3_nobyp", 32'h0);     check(b0.rd[31:0]);

        // Port 0 write, then PC and stored reads on three ports.
        we0 = 1'b1; wa0 = 4'd5; wd0 = 32'h1234_5678;
        tick(); idle();
        ra = {4'd5, 4'd5, 4'd15};
        #1;
        expect_val("rd0_pc", 32'h0000_0100);     check(b1.rd[31:0]);
        expect_val("rd1_r5", 32'h1234_5678);     check(b1.rd[63:32]);
        expect_val("rd2_r5", 32'h1234_5678);     check(b1.rd[95:64]);

        // Writes to the PC address are dropped and never bypassed, even on both ports.
        we0 = 1'b1; wa0 = 4'd15; wd0 = 32'hFFFF_FFFF;
        we1 = 1'b1; wa1 = 4'd15; wd1 = 32'hEEEE_EEEE;
        #1;
        expect_val("pc_no_bypass", 32'h0000_0100); check(b1.rd[31:0]);
        tick(); idle();
        expect_val("pc_wr_r5_intact", 32'h1234_5678); check(b1.rd[63:32]);
        expect_val("pc_wr_no_conflict", 32'h0);       check(32'(b1.wr_conflict));
        expect_val("pc_wr_busy_vec", 32'h0);          check(32'(b1.busy_vec));

        // Bypass versus pre-write value.
        ra = {4'd0, 4'd0, 4'd7};
        we0 = 1'b1; wa0 = 4'd7; wd0 = 32'h0BAD_0007;
        tick(); idle();
        we1 = 1'b1; wa1 = 4'd7; wd1 = 32'hA5A5_A5A5;
        #1;
        expect_val("bypass_wd1", 32'hA5A5_A5A5);  check(b1.rd[31:0]);
        expect_val("nobyp_old_r7", 32'h0BAD_0007); check(b0.rd[31:0]);
        tick(); idle();
        expect_val("nobyp_new_r7", 32'hA5A5_A5A5); check(b0.rd[31:0]);
        we0 = 1'b1; wa0 = 4'd7; wd0 = 32'h0000_0001;
        we1 = 1'b1; wa1 = 4'd7; wd1 = 32'h0000_0002;
        #1;
        expect_val("bypass_port0_priority", 32'h0000_0001); check(b1.rd[31:0]);
        idle();

        // Dual write to r2: port 0 data kept, one-cycle conflict flag.
        ra = {4'd0, 4'd0, 4'd2};
        we0 = 1'b1; wa0 = 4'd2; wd0 = 32'h11;
        we1 = 1'b1; wa1 = 4'd2; wd1 = 32'h22;
        tick(); idle();
        expect_val("collision_r2", 32'h11);       check(b1.rd[31:0]);
        expect_val("collision_flag_set", 32'h1);  check(32'(b1.wr_conflict));
        tick();
        expect_val("collision_flag_clr", 32'h0);  check(32'(b1.wr_conflict));

        // Scoreboard set, set-beats-clear, clear, ignored PC set.
        ra = {4'd15, 4'd4, 4'd2};
        bset = 1'b1; bset_addr = 4'd4;
        tick(); idle();
        expect_val("sb_set_busy_vec", 32'h0010);  check(32'(b1.busy_vec));
        expect_val("sb_set_rd_busy", 32'h2);      check(32'(b1.rd_busy));
        bset = 1'b1; bset_addr = 4'd4;
        we1 = 1'b1; wa1 = 4'd4; wd1 = 32'h44;
        tick(); idle();
        expect_val("sb_set_wins", 32'h0010);      check(32'(b1.busy_vec));
        we0 = 1'b1; wa0 = 4'd4; wd0 = 32'h45;
        tick(); idle();
        expect_val("sb_clear", 32'h0);            check(32'(b1.busy_vec));
        expect_val("sb_clear_rd_busy", 32'h0);    check(32'(b1.rd_busy));
        bset = 1'b1; bset_addr = 4'd15;
        tick(); idle();
        expect_val("sb_pc_ignored", 32'h0);       check(32'(b1.busy_vec));

        // Reset in the middle of a pending write to r9.
        ra = {4'd0, 4'd0, 4'd9};
        bset = 1'b1; bset_addr = 4'd9;
        we0 = 1'b1; wa0 = 4'd9; wd0 = 32'h99;
        tick(); idle();
        expect_val("pre_reset_r9", 32'h99);       check(b1.rd[31:0]);
        expect_val("pre_reset_busy", 32'h0200);   check(32'(b1.busy_vec));
        expect_val("pre_reset_rd_busy", 32'h1);   check(32'(b1.rd_busy));
        reset = 1'b0;
        we0 = 1'b1; wa0 = 4'd9; wd0 = 32'h77;
        bset = 1'b1; bset_addr = 4'd9;
        tick();
        reset = 1'b1; idle();
        expect_val("post_reset_r9", 32'h0);       check(b1.rd[31:0]);
        expect_val("post_reset_busy", 32'h0);     check(32'(b1.busy_vec));
        expect_val("post_reset_r9_nobyp", 32'h0); check(b0.rd[31:0]);

        if (exp_q.size() != 0) begin
            fails++;
            $error("FAIL scoreboard_leftover: observed %0d unchecked entries expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end
endmodule
